// File: rtl/mem_router.sv
// mem_router: registered one-outstanding-request router from the CPU load/store port to
// local memory and N memory-mapped peripheral windows, with error and timeout responses.
module mem_router #(
  parameter int          N_PERIPH         = 2,
  parameter int          LOCAL_ADDR_BITS  = 20,
  parameter logic [31:0] PERIPH_BASE      = 32'hF000_0000,
  parameter int          PERIPH_ADDR_BITS = 12,
  parameter int          TIMEOUT          = 64
) (
  input  logic                        CLK_CPU,
  input  logic                        resetp,
  input  logic                        cpu_req_valid,
  output logic                        cpu_req_ready,
  input  logic [31:0]                 cpu_req_addr,
  input  logic [1:0]                  cpu_req_size,
  input  logic [31:0]                 cpu_req_wdata,
  output logic                        cpu_rsp_valid,
  output logic [31:0]                 cpu_rsp_rdata,
  output logic                        cpu_rsp_err,
  output logic                        mem_valid,
  output logic                        mem_we,
  output logic [3:0]                  mem_be,
  output logic [LOCAL_ADDR_BITS-1:0]  mem_addr,
  output logic [31:0]                 mem_wdata,
  input  logic                        mem_ack,
  input  logic [31:0]                 mem_rdata,
  output logic [N_PERIPH-1:0]         per_valid,
  output logic                        per_we,
  output logic [3:0]                  per_be,
  output logic [PERIPH_ADDR_BITS-1:0] per_addr,
  output logic [31:0]                 per_wdata,
  input  logic [N_PERIPH-1:0]         per_ack,
  input  logic [N_PERIPH*32-1:0]      per_rdata
);

  // state | meaning
  // IDLE  | ready for a request
  // BUSY  | one target selected, waiting for its ack or the timeout
  // RESP  | one-cycle completion pulse to the CPU
  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_e;

  localparam logic [7:0]  CNT_LAST   = 8'(TIMEOUT - 1);
  localparam logic [31:0] N_PERIPH_W = 32'(N_PERIPH);

  state_e                      state_q, state_d;
  logic                        ready_q, ready_d;
  logic                        rsp_valid_q, rsp_valid_d;
  logic                        rsp_err_q, rsp_err_d;
  logic [31:0]                 rsp_rdata_q, rsp_rdata_d;
  logic                        mem_valid_q, mem_valid_d;
  logic [N_PERIPH-1:0]         per_valid_q, per_valid_d;
  logic                        we_q, we_d;
  logic [3:0]                  be_q, be_d;
  logic [LOCAL_ADDR_BITS-1:0]  mem_addr_q, mem_addr_d;
  logic [PERIPH_ADDR_BITS-1:0] per_addr_q, per_addr_d;
  logic [31:0]                 wdata_q, wdata_d;
  logic [7:0]                  cnt_q, cnt_d;

  logic                        misalign_w;
  logic                        is_local_w;
  logic                        is_periph_w;
  logic [32:0]                 per_off_w;
  logic [31:0]                 per_idx_w;
  logic [N_PERIPH-1:0]         per_sel_w;
  logic [3:0]                  be_w;
  logic [31:0]                 wdata_w;
  logic                        ack_w;
  logic [31:0]                 tgt_rdata_w;

  // Request decode: alignment, window match, lanes and replicated store data.
  always_comb begin
    case (cpu_req_size)
      2'b01:   misalign_w = cpu_req_addr[0];
      2'b10,
      2'b11:   misalign_w = |cpu_req_addr[1:0];
      default: misalign_w = 1'b0;
    endcase

    is_local_w  = (cpu_req_addr[31:LOCAL_ADDR_BITS] == '0);
    // The extra bit catches addresses below PERIPH_BASE instead of letting them wrap.
    per_off_w   = {1'b0, cpu_req_addr} - {1'b0, PERIPH_BASE};
    per_idx_w   = per_off_w[31:0] >> PERIPH_ADDR_BITS;
    is_periph_w = !per_off_w[32] && (per_idx_w < N_PERIPH_W);

    per_sel_w = '0;
    for (int k = 0; k < N_PERIPH; k++) begin
      per_sel_w[k] = (per_idx_w == 32'(k));
    end

    case (cpu_req_size)
      2'b00:   be_w = 4'b0001 << cpu_req_addr[1:0];
      2'b01:   be_w = 4'b0011 << {cpu_req_addr[1], 1'b0};
      default: be_w = 4'b1111;
    endcase

    case (cpu_req_size)
      2'b00:   wdata_w = {4{cpu_req_wdata[7:0]}};
      2'b01:   wdata_w = {2{cpu_req_wdata[15:0]}};
      default: wdata_w = cpu_req_wdata;
    endcase
  end

  // Only the channel whose valid we are driving may complete the access.
  always_comb begin
    ack_w       = (mem_valid_q & mem_ack) | (|(per_valid_q & per_ack));
    tgt_rdata_w = mem_valid_q ? mem_rdata : 32'h0;
    for (int k = 0; k < N_PERIPH; k++) begin
      if (per_valid_q[k]) begin
        tgt_rdata_w = per_rdata[32*k +: 32];
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    ready_d     = ready_q;
    rsp_valid_d = 1'b0;
    rsp_err_d   = rsp_err_q;
    rsp_rdata_d = rsp_rdata_q;
    mem_valid_d = mem_valid_q;
    per_valid_d = per_valid_q;
    we_d        = we_q;
    be_d        = be_q;
    mem_addr_d  = mem_addr_q;
    per_addr_d  = per_addr_q;
    wdata_d     = wdata_q;
    cnt_d       = cnt_q;

    case (state_q)
      IDLE: begin
        if (cpu_req_valid) begin
          ready_d    = 1'b0;
          we_d       = (cpu_req_size != 2'b11);
          be_d       = be_w;
          wdata_d    = wdata_w;
          mem_addr_d = cpu_req_addr[LOCAL_ADDR_BITS-1:0];
          per_addr_d = cpu_req_addr[PERIPH_ADDR_BITS-1:0];
          cnt_d      = 8'h00;
          if (misalign_w || !(is_local_w || is_periph_w)) begin
            state_d     = RESP;
            rsp_valid_d = 1'b1;
            rsp_err_d   = 1'b1;
            rsp_rdata_d = 32'h0;
          end else begin
            state_d     = BUSY;
            mem_valid_d = is_local_w;
            per_valid_d = is_local_w ? '0 : per_sel_w;
          end
        end
      end
      BUSY: begin
        if (ack_w) begin
          state_d     = RESP;
          mem_valid_d = 1'b0;
          per_valid_d = '0;
          rsp_valid_d = 1'b1;
          rsp_err_d   = 1'b0;
          rsp_rdata_d = we_q ? 32'h0 : tgt_rdata_w;
        end else if (cnt_q == CNT_LAST) begin
          state_d     = RESP;
          mem_valid_d = 1'b0;
          per_valid_d = '0;
          rsp_valid_d = 1'b1;
          rsp_err_d   = 1'b1;
          rsp_rdata_d = 32'h0;
        end else begin
          cnt_d = cnt_q + 8'h01;
        end
      end
      RESP: begin
        state_d = IDLE;
        ready_d = 1'b1;
      end
      default: begin
        state_d     = IDLE;
        ready_d     = 1'b1;
        mem_valid_d = 1'b0;
        per_valid_d = '0;
      end
    endcase
  end

  always_ff @(posedge CLK_CPU or posedge resetp) begin
    if (resetp) begin
      state_q     <= IDLE;
      ready_q     <= 1'b1;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_rdata_q <= 32'h0;
      mem_valid_q <= 1'b0;
      per_valid_q <= '0;
      we_q        <= 1'b0;
      be_q        <= 4'h0;
      mem_addr_q  <= '0;
      per_addr_q  <= '0;
      wdata_q     <= 32'h0;
      cnt_q       <= 8'h00;
    end else begin
      state_q     <= state_d;
      ready_q     <= ready_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_err_q   <= rsp_err_d;
      rsp_rdata_q <= rsp_rdata_d;
      mem_valid_q <= mem_valid_d;
      per_valid_q <= per_valid_d;
      we_q        <= we_d;
      be_q        <= be_d;
      mem_addr_q  <= mem_addr_d;
      per_addr_q  <= per_addr_d;
      wdata_q     <= wdata_d;
      cnt_q       <= cnt_d;
    end
  end

  assign cpu_req_ready = ready_q;
  assign cpu_rsp_valid = rsp_valid_q;
  assign cpu_rsp_err   = rsp_err_q;
  assign cpu_rsp_rdata = rsp_rdata_q;
  assign mem_valid     = mem_valid_q;
  assign mem_we        = we_q;
  assign mem_be        = be_q;
  assign mem_addr      = mem_addr_q;
  assign mem_wdata     = wdata_q;
  assign per_valid     = per_valid_q;
  assign per_we        = we_q;
  assign per_be        = be_q;
  assign per_addr      = per_addr_q;
  assign per_wdata     = wdata_q;

endmodule

// File: tb/tb_mem_router.sv
// Randomized bench for mem_router: a transaction-level timeline model predicts every
// cycle's handshake and target-bus values, checked by one compare process.
module tb_mem_router;
  localparam int          N_PERIPH = 2;
  localparam int          TIMEOUT  = 8;
  localparam logic [31:0] PBASE    = 32'hF000_0000;

  logic                  CLK_CPU = 1'b0;
  logic                  resetp;
  logic                  cpu_req_valid;
  logic                  cpu_req_ready;
  logic [31:0]           cpu_req_addr;
  logic [1:0]            cpu_req_size;
  logic [31:0]           cpu_req_wdata;
  logic                  cpu_rsp_valid;
  logic [31:0]           cpu_rsp_rdata;
  logic                  cpu_rsp_err;
  logic                  mem_valid;
  logic                  mem_we;
  logic [3:0]            mem_be;
  logic [19:0]           mem_addr;
  logic [31:0]           mem_wdata;
  logic                  mem_ack;
  logic [31:0]           mem_rdata;
  logic [N_PERIPH-1:0]   per_valid;
  logic                  per_we;
  logic [3:0]            per_be;
  logic [11:0]           per_addr;
  logic [31:0]           per_wdata;
  logic [N_PERIPH-1:0]   per_ack;
  logic [N_PERIPH*32-1:0] per_rdata;

  always #5 CLK_CPU = ~CLK_CPU;

  mem_router #(
    .N_PERIPH(N_PERIPH), .LOCAL_ADDR_BITS(20), .PERIPH_BASE(PBASE),
    .PERIPH_ADDR_BITS(12), .TIMEOUT(TIMEOUT)
  ) dut (
    .CLK_CPU(CLK_CPU), .resetp(resetp),
    .cpu_req_valid(cpu_req_valid), .cpu_req_ready(cpu_req_ready),
    .cpu_req_addr(cpu_req_addr), .cpu_req_size(cpu_req_size), .cpu_req_wdata(cpu_req_wdata),
    .cpu_rsp_valid(cpu_rsp_valid), .cpu_rsp_rdata(cpu_rsp_rdata), .cpu_rsp_err(cpu_rsp_err),
    .mem_valid(mem_valid), .mem_we(mem_we), .mem_be(mem_be), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .per_valid(per_valid), .per_we(per_we), .per_be(per_be), .per_addr(per_addr),
    .per_wdata(per_wdata), .per_ack(per_ack), .per_rdata(per_rdata)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  always @(posedge CLK_CPU) cyc <= cyc + 1;

  // Expected timeline of the current transaction, in cycles counted from reset.
  bit          chk_en  = 1'b0;
  bit          tx_live = 1'b0;
  int          t_acc, v_last, rsp_cyc, tgt;  // tgt: -1 none, 0 local, k+1 peripheral k
  logic        e_we, e_err;
  logic [3:0]  e_be;
  logic [31:0] e_addr, e_wdata, e_rdata;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at cyc %0d: actual %h required %h", nm, cyc, act, exp);
    end
  endtask

  function automatic int m_target(input logic [31:0] a);
    longint ua = longint'(a);
    if (ua < 64'h10_0000) return 0;
    if (ua >= longint'(PBASE) && ua < longint'(PBASE) + N_PERIPH * 4096)
      return 1 + int'((ua - longint'(PBASE)) / 4096);
    return -1;
  endfunction

  function automatic bit m_misaligned(input logic [31:0] a, input logic [1:0] sz);
    if (sz == 2'b01) return (a % 2) != 0;
    if (sz[1]) return (a % 4) != 0;
    return 1'b0;
  endfunction

  function automatic logic [3:0] m_be(input logic [31:0] a, input logic [1:0] sz);
    case (sz)
      2'b00:   return 4'(1 << (a % 4));
      2'b01:   return ((a % 4) < 2) ? 4'd3 : 4'd12;
      default: return 4'hF;
    endcase
  endfunction

  function automatic logic [31:0] m_rep(input logic [31:0] d, input logic [1:0] sz);
    case (sz)
      2'b00:   return (d & 32'hFF) * 32'h0101_0101;
      2'b01:   return (d & 32'hFFFF) * 32'h0001_0001;
      default: return d;
    endcase
  endfunction

  // Compare process: sampled 3 time units after each rising edge.
  initial begin
    bit busy, rsp, rdy;
    logic b_we;
    logic [3:0] b_be;
    logic [31:0] b_addr, b_wdata;
    forever begin
      @(posedge CLK_CPU);
      #3;
      if (chk_en) begin
        busy = tx_live && tgt >= 0 && cyc >= t_acc && cyc <= v_last;
        rsp  = tx_live && cyc == rsp_cyc;
        rdy  = !(tx_live && cyc >= t_acc && cyc <= rsp_cyc);
        chk("ready", 32'(cpu_req_ready), 32'(rdy));
        chk("rsp_valid", 32'(cpu_rsp_valid), 32'(rsp));
        chk("mem_valid", 32'(mem_valid), 32'(busy && tgt == 0));
        chk("per_valid", 32'(per_valid), (busy && tgt > 0) ? 32'(1 << (tgt - 1)) : 32'h0);
        if (busy) begin
          if (tgt == 0) begin
            b_we = mem_we; b_be = mem_be; b_addr = 32'(mem_addr); b_wdata = mem_wdata;
          end else begin
            b_we = per_we; b_be = per_be; b_addr = 32'(per_addr); b_wdata = per_wdata;
          end
          chk("we", 32'(b_we), 32'(e_we));
          chk("be", 32'(b_be), 32'(e_be));
          chk("addr", b_addr, e_addr);
          if (e_we) chk("wdata", b_wdata, e_wdata);
        end
        if (rsp) begin
          chk("rsp_err", 32'(cpu_rsp_err), 32'(e_err));
          chk("rsp_rdata", cpu_rsp_rdata, e_rdata);
        end
      end
    end
  end

  // One transaction: lat = cycles from accept until the target's ack is sampled.
  // abort_at > 0 asserts reset on that BUSY cycle instead of completing.
  task automatic do_tx(input logic [31:0] addr, input logic [1:0] sz, input logic [31:0] wd,
                       input int lat, input logic [31:0] rd, input int abort_at);
    int a_eff;
    int ack_cyc;
    @(negedge CLK_CPU);
    cpu_req_valid = 1'b1;
    cpu_req_addr  = addr;
    cpu_req_size  = sz;
    cpu_req_wdata = wd;
    tgt = m_misaligned(addr, sz) ? -1 : m_target(addr);
    t_acc   = cyc + 1;
    e_we    = (sz != 2'b11);
    e_be    = m_be(addr, sz);
    e_wdata = m_rep(wd, sz);
    e_addr  = (tgt == 0) ? (addr & 32'h000F_FFFF) : ((addr - PBASE) % 4096);
    if (tgt < 0) begin
      e_err = 1'b1; rsp_cyc = t_acc; v_last = t_acc - 1;
    end else begin
      a_eff   = (lat < TIMEOUT) ? lat : TIMEOUT;
      e_err   = (lat > TIMEOUT);
      v_last  = t_acc + a_eff - 1;
      rsp_cyc = t_acc + a_eff;
    end
    e_rdata = (!e_we && !e_err) ? rd : 32'h0;
    tx_live = 1'b1;
    ack_cyc = t_acc + lat - 1;
    do begin
      @(negedge CLK_CPU);
      cpu_req_valid = 1'b0;
      cpu_req_addr  = $urandom;
      cpu_req_size  = 2'($urandom_range(0, 3));
      cpu_req_wdata = $urandom;
      if (abort_at > 0 && cyc == t_acc + abort_at - 1) begin
        tx_live = 1'b0;
        resetp  = 1'b1;
        #1;
        chk("rst_mem_valid", 32'(mem_valid), 32'h0);
        chk("rst_ready", 32'(cpu_req_ready), 32'h1);
        chk("rst_rsp_valid", 32'(cpu_rsp_valid), 32'h0);
        return;
      end
      mem_ack   = (tgt == 0) ? (cyc == ack_cyc) : 1'($urandom_range(0, 1));
      mem_rdata = (tgt == 0 && cyc == ack_cyc) ? rd : $urandom;
      for (int k = 0; k < N_PERIPH; k++) begin
        per_ack[k] = (tgt == k + 1) ? (cyc == ack_cyc) : 1'($urandom_range(0, 1));
        per_rdata[32*k +: 32] = (tgt == k + 1 && cyc == ack_cyc) ? rd : $urandom;
      end
    end while (cyc < rsp_cyc);
  endtask

  task automatic lit_rsp(input string nm, input logic err, input logic [31:0] rd);
    chk({nm, "_valid"}, 32'(cpu_rsp_valid), 32'h1);
    chk({nm, "_err"}, 32'(cpu_rsp_err), 32'(err));
    chk({nm, "_rdata"}, cpu_rsp_rdata, rd);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: actual no finish required finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] a;
    logic [1:0]  sz;
    resetp = 1'b1; cpu_req_valid = 1'b0; cpu_req_addr = '0; cpu_req_size = '0;
    cpu_req_wdata = '0; mem_ack = 1'b0; mem_rdata = '0; per_ack = '0; per_rdata = '0;

    chk("pin_be_byte3", 32'(m_be(32'hF000_1003, 2'b00)), 32'h8);
    chk("pin_be_half2", 32'(m_be(32'h0000_0002, 2'b01)), 32'hC);
    chk("pin_rep_byte", m_rep(32'h0000_005A, 2'b00), 32'h5A5A_5A5A);
    chk("pin_rep_half", m_rep(32'h1234_BEEF, 2'b01), 32'hBEEF_BEEF);
    chk("pin_tgt_local", 32'(m_target(32'h0000_0104)), 32'h0);
    chk("pin_tgt_per1", 32'(m_target(32'hF000_1003)), 32'h2);
    chk("pin_tgt_hole", 32'(m_target(32'h8000_0000)), 32'hFFFF_FFFF);
    chk("pin_tgt_past", 32'(m_target(32'hF000_2000)), 32'hFFFF_FFFF);
    chk("pin_misalign", 32'(m_misaligned(32'h0000_0002, 2'b10)), 32'h1);

    repeat (3) @(negedge CLK_CPU);
    chk("reset_ready", 32'(cpu_req_ready), 32'h1);
    chk("reset_rsp_valid", 32'(cpu_rsp_valid), 32'h0);
    chk("reset_rsp_err", 32'(cpu_rsp_err), 32'h0);
    chk("reset_rsp_rdata", cpu_rsp_rdata, 32'h0);
    chk("reset_mem_valid", 32'(mem_valid), 32'h0);
    chk("reset_per_valid", 32'(per_valid), 32'h0);
    chk("reset_mem_be", 32'(mem_be), 32'h0);
    chk("reset_wdata", per_wdata, 32'h0);
    resetp = 1'b0;
    chk_en = 1'b1;

    do_tx(32'h0000_0104, 2'b11, 32'h0, 1, 32'hDEAD_BEEF, 0);
    lit_rsp("local_load", 1'b0, 32'hDEAD_BEEF);
    do_tx(32'hF000_1003, 2'b00, 32'h0000_005A, 3, 32'h1111_1111, 0);
    lit_rsp("per1_byte", 1'b0, 32'h0);
    do_tx(32'h8000_0000, 2'b11, 32'h0, 1, 32'h2222_2222, 0);
    lit_rsp("unmapped", 1'b1, 32'h0);
    do_tx(32'h0000_0002, 2'b10, 32'hCAFE_F00D, 1, 32'h0, 0);
    lit_rsp("misalign", 1'b1, 32'h0);
    do_tx(32'hF000_0010, 2'b10, 32'hA5A5_0001, 100, 32'h0, 0);
    lit_rsp("timeout", 1'b1, 32'h0);
    do_tx(32'hF000_0010, 2'b11, 32'h0, TIMEOUT, 32'h7777_0008, 0);
    lit_rsp("ack_at_limit", 1'b0, 32'h7777_0008);
    do_tx(32'h0000_0200, 2'b11, 32'h0, 4, 32'h1234_5678, 0);
    lit_rsp("stray_ack", 1'b0, 32'h1234_5678);

    do_tx(32'h0000_0040, 2'b10, 32'h0BAD_0BAD, 6, 32'h0, 2);
    @(negedge CLK_CPU);
    resetp = 1'b0;
    repeat (4) @(negedge CLK_CPU);
    chk("post_reset_ready", 32'(cpu_req_ready), 32'h1);

    for (int i = 0; i < 200; i++) begin
      case ($urandom_range(0, 5))
        0, 1:    a = $urandom & 32'h000F_FFFF;
        2, 3:    a = PBASE + 32'($urandom_range(0, N_PERIPH * 4096 - 1));
        4:       a = 32'h0010_0000 + $urandom_range(0, 32'h1000_0000);
        default: a = PBASE + 32'(N_PERIPH * 4096) + $urandom_range(0, 32'h0100_0000);
      endcase
      sz = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 3) != 0) begin
        if (sz == 2'b01) a[0] = 1'b0;
        else if (sz[1]) a[1:0] = 2'b00;
      end
      do_tx(a, sz, $urandom, $urandom_range(1, TIMEOUT + 2), $urandom, 0);
      repeat ($urandom_range(0, 2)) @(negedge CLK_CPU);
    end

    repeat (3) @(negedge CLK_CPU);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
